mips_multicycle_core: RTL and testbench
=======================================

MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter ADDR_W, default 32, legal 8..32: width of mem_addr, driven from bits [ADDR_W-1:0] of the internal 32-bit address.
REQ-003 Port CLK  input  1: single clock, all state updates on rising edge.
REQ-004 Port RST_N  input  1: reset, asynchronous, active-low.
REQ-005 Port mem_req  output  1: memory transaction request, shared instruction/data port.
REQ-006 Port mem_we  output  1: 1 = write, 0 = read; valid while mem_req=1.
REQ-007 Port mem_addr  output  ADDR_W: byte address, word-aligned.
REQ-008 Port mem_wdata  output  32: store data.
REQ-009 Port mem_rdata  input  32: read data, valid in the cycle mem_ready=1.
REQ-010 Port mem_ready  input  1: transaction completes on a rising edge where mem_req=1 and mem_ready=1.
REQ-011 Port pc  output  32: current PC, for debug.
REQ-012 Port retired  output  1: one-cycle pulse in the cycle an instruction completes.
REQ-013 Port err  output  1: sticky trap flag.

Function
REQ-014 The core SHALL implement a multicycle MIPS datapath sharing one ALU and one memory port, with an internal 32x32 register file; register 0 SHALL read 0, and writes to it SHALL be discarded.
REQ-015 Supported instructions SHALL be: R-type add, sub, and, or, slt (op 0, funct 20/22/24/25/2A hex); lw (23); sw (2B); beq (04); addi (08); j (02); jal (03).
REQ-016 ALU encoding SHALL be: 010 add, 110 sub, 000 and, 001 or, 111 slt (signed); add/sub SHALL wrap modulo 2^32 with no overflow trap.
REQ-017 The FSM SHALL use states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, JAL and TRAP.
REQ-018 FETCH SHALL assert mem_req=1, mem_we=0 and mem_addr=pc; on completion it SHALL latch IR<=mem_rdata and pc<=pc+4, then go to DECODE.
REQ-019 DECODE SHALL latch A<=rf[IR[25:21]] and B<=rf[IR[20:16]], then dispatch on opcode.
REQ-020 An undefined opcode or funct SHALL go to TRAP.
REQ-021 lw path SHALL be MEMADR (ALUOut<=A+sext(imm)) -> MEMRD (read at ALUOut, latch MDR) -> MEMWB (rf[rt]<=MDR).
REQ-022 sw path SHALL be MEMADR -> MEMWR (mem_we=1, mem_wdata=B).
REQ-023 R-type SHALL be EXEC -> ALUWB (rf[rd]<=ALUOut).
REQ-024 addi SHALL be ADDIEX -> ADDIWB (rf[rt]<=ALUOut).
REQ-025 beq SHALL, in BRANCH, set pc<=pc+(sext(imm)<<2) if A==B, else leave pc unchanged; pc here is the already-incremented PC+4.
REQ-026 JUMP SHALL set pc<={pc[31:28],IR[25:0],2'b00}.
REQ-027 JAL SHALL apply the same target as JUMP and also write rf[31]<=pc (PC+4), in the same cycle.
REQ-028 Every final state (MEMWB, MEMWR completion, ALUWB, ADDIWB, BRANCH, JUMP, JAL) SHALL pulse retired=1 and return to FETCH.
REQ-029 With mem_ready tied 1, latency in cycles SHALL be: beq/j/jal 3, R-type/addi/sw 4, lw 5.
REQ-030 mem_req, mem_we, mem_addr and mem_wdata SHALL be held stable until completion; the FSM SHALL NOT advance while mem_ready=0.
REQ-031 mem_ready while mem_req=0 SHALL be ignored.
REQ-032 In MEMADR, a computed address with bits [1:0]!=0 SHALL go to TRAP without asserting mem_req.
REQ-033 TRAP SHALL set err=1, assert mem_req=0, freeze pc and the registers, and remain in TRAP until reset.
REQ-034 Branch and jump targets SHALL wrap modulo 2^32.

Reset
REQ-035 While RST_N=0, outputs SHALL be: state=FETCH, pc=RESET_PC, mem_req=0, mem_we=0, retired=0, err=0, IR/A/B/ALUOut/MDR=0, all registers=0.
REQ-036 Reset asserted mid-transaction SHALL drop mem_req asynchronously; no register or memory write from the aborted instruction SHALL occur.
REQ-037 After RST_N rises, the first rising edge SHALL begin FETCH at RESET_PC.

Verification
REQ-038 Scenario: addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 with mem_ready=1 -> $3=12, retired pulses at cycles 4, 8 and 12.
REQ-039 Scenario: sw $3,8($0); lw $4,8($0) -> write at addr 8 with data 12; $4=12; lw takes 5 cycles.
REQ-040 Scenario: beq $1,$1,-1 at PC 0x10 -> pc returns to 0x10 each 3 cycles; beq $1,$2 (unequal) -> pc=0x14.
REQ-041 Scenario: jal 0x40 at PC 0x20 -> pc=0x100, $31=0x24; add $0,$1,$2 leaves $0=0.
REQ-042 Scenario: mem_ready held 0 for 3 cycles during FETCH -> mem_addr stable and state frozen, fetch completes on the 4th edge; lw from addr 6 -> err=1, no mem_req.
REQ-043 Scenario: RST_N pulsed low during MEMWR with mem_ready=0 -> mem_req=0 immediately, pc=RESET_PC, no write observed.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset: one shared ALU, one shared memory port,
// internal 32x32 register file, sticky trap on illegal or misaligned ops.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic              retired,
  output logic              err
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, JAL, TRAP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_alu_out;
  logic [31:0] r_mdr;
  logic [31:0] r_rf [32];

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_sext;
  logic [31:0] w_jtarget;
  logic [31:0] w_addr;
  logic [2:0]  w_fn_ctl;
  logic        w_fn_ok;
  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [2:0]  w_alu_ctl;
  logic [31:0] w_alu_y;

  assign w_op      = r_ir[31:26];
  assign w_funct   = r_ir[5:0];
  assign w_rs      = r_ir[25:21];
  assign w_rt      = r_ir[20:16];
  assign w_rd      = r_ir[15:11];
  assign w_sext    = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_jtarget = {r_pc[31:28], r_ir[25:0], 2'b00};

  always_comb begin
    w_fn_ctl = 3'b010;
    w_fn_ok  = 1'b1;
    case (w_funct)
      6'h20:   w_fn_ctl = 3'b010;
      6'h22:   w_fn_ctl = 3'b110;
      6'h24:   w_fn_ctl = 3'b000;
      6'h25:   w_fn_ctl = 3'b001;
      6'h2A:   w_fn_ctl = 3'b111;
      default: w_fn_ok  = 1'b0;
    endcase
  end

  // The single ALU also forms PC+4 in FETCH and the branch target.
  always_comb begin
    w_alu_a   = r_a;
    w_alu_b   = w_sext;
    w_alu_ctl = 3'b010;
    case (r_state)
      FETCH: begin
        w_alu_a = r_pc;
        w_alu_b = 32'd4;
      end
      EXEC: begin
        w_alu_b   = r_b;
        w_alu_ctl = w_fn_ctl;
      end
      BRANCH: begin
        w_alu_a = r_pc;
        w_alu_b = {w_sext[29:0], 2'b00};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (w_alu_ctl)
      3'b110:  w_alu_y = w_alu_a - w_alu_b;
      3'b000:  w_alu_y = w_alu_a & w_alu_b;
      3'b001:  w_alu_y = w_alu_a | w_alu_b;
      3'b111:  w_alu_y = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
      default: w_alu_y = w_alu_a + w_alu_b;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    retired = 1'b0;
    case (r_state)
      FETCH: if (mem_ready) w_next = DECODE;
      DECODE: begin
        case (w_op)
          6'h00:        w_next = w_fn_ok ? EXEC : TRAP;
          6'h23, 6'h2B: w_next = MEMADR;
          6'h04:        w_next = BRANCH;
          6'h08:        w_next = ADDIEX;
          6'h02:        w_next = JUMP;
          6'h03:        w_next = JAL;
          default:      w_next = TRAP;
        endcase
      end
      MEMADR: begin
        if (w_alu_y[1:0] != 2'b00) w_next = TRAP;
        else if (w_op == 6'h23)    w_next = MEMRD;
        else                       w_next = MEMWR;
      end
      MEMRD: if (mem_ready) w_next = MEMWB;
      MEMWR: begin
        if (mem_ready) begin
          retired = 1'b1;
          w_next  = FETCH;
        end
      end
      EXEC:   w_next = ALUWB;
      ADDIEX: w_next = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, JAL: begin
        retired = 1'b1;
        w_next  = FETCH;
      end
      default: w_next = TRAP;
    endcase
  end

  // Gating with RST_N drops the request the moment reset asserts.
  assign w_addr    = (r_state == FETCH) ? r_pc : r_alu_out;
  assign mem_req   = RST_N & ((r_state == FETCH) |
                              (r_state == MEMRD) |
                              (r_state == MEMWR));
  assign mem_we    = RST_N & (r_state == MEMWR);
  assign mem_addr  = w_addr[ADDR_W-1:0];
  assign mem_wdata = r_b;
  assign pc        = r_pc;
  assign err       = (r_state == TRAP);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        FETCH: begin
          if (mem_ready) begin
            r_ir <= mem_rdata;
            r_pc <= w_alu_y;
          end
        end
        DECODE: begin
          r_a <= r_rf[w_rs];
          r_b <= r_rf[w_rt];
        end
        MEMADR, EXEC, ADDIEX: r_alu_out <= w_alu_y;
        MEMRD: if (mem_ready) r_mdr <= mem_rdata;
        MEMWB:  if (w_rt != 5'd0) r_rf[w_rt] <= r_mdr;
        ALUWB:  if (w_rd != 5'd0) r_rf[w_rd] <= r_alu_out;
        ADDIWB: if (w_rt != 5'd0) r_rf[w_rt] <= r_alu_out;
        BRANCH: if (r_a == r_b) r_pc <= w_alu_y;
        JUMP:   r_pc <= w_jtarget;
        JAL: begin
          r_pc      <= w_jtarget;
          r_rf[31]  <= r_pc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: directed program table, stall/trap/
// reset corner sequences, and a random program against an ISA model.
module tb_mips_multicycle_core;

  logic        CLK;
  logic        RST_N;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] pc;
  logic        retired;
  logic        err;

  mips_multicycle_core dut (
    .CLK(CLK), .RST_N(RST_N),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .retired(retired), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] mem [256];
  assign mem_rdata = mem[mem_addr[9:2]];

  int          n_vec = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;
  bit          rnd_rdy = 1'b0;

  logic [31:0] m_rf [32];
  logic [31:0] m_mem [256];
  logic [31:0] m_pc;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ins;
    int          lat;
    logic [31:0] npc;
    bit          wr;
    logic [31:0] wa;
    logic [31:0] wd;
  } vec_t;

  vec_t tv [19];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn,
    input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op,
    input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op,
    input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  function automatic logic [31:0] rand_ins();
    int k;
    logic [4:0] d, s, t;
    logic [15:0] da;
    k  = $urandom_range(0, 8);
    d  = 5'($urandom_range(0, 31));
    s  = 5'($urandom_range(0, 31));
    t  = 5'($urandom_range(0, 31));
    da = 16'(32'h200 + 4 * $urandom_range(0, 15));
    case (k)
      0:       return enc_i(6'h08, t, s, 16'($urandom));
      1:       return enc_r(6'h20, d, s, t);
      2:       return enc_r(6'h22, d, s, t);
      3:       return enc_r(6'h24, d, s, t);
      4:       return enc_r(6'h25, d, s, t);
      5:       return enc_r(6'h2A, d, s, t);
      6:       return enc_i(6'h2B, t, 5'd0, da);
      7:       return enc_i(6'h23, t, 5'd0, da);
      default: return enc_i(6'h04, t, s, 16'($urandom_range(0, 3)));
    endcase
  endfunction

  // Architectural reference: one whole instruction per call.
  task automatic model_step(output bit wr, output logic [31:0] wa,
    output logic [31:0] wd, output int lat);
    logic [31:0] ins, a, b, sx, nxt, res, ea;
    logic [4:0]  dst;
    bit          wreg;
    ins  = m_mem[m_pc[9:2]];
    a    = m_rf[ins[25:21]];
    b    = m_rf[ins[20:16]];
    sx   = {{16{ins[15]}}, ins[15:0]};
    ea   = a + sx;
    nxt  = m_pc + 32'd4;
    wr   = 1'b0;
    wa   = '0;
    wd   = '0;
    lat  = 4;
    wreg = 1'b0;
    dst  = ins[20:16];
    res  = '0;
    case (ins[31:26])
      6'h00: begin
        wreg = 1'b1;
        dst  = ins[15:11];
        case (ins[5:0])
          6'h20:   res = a + b;
          6'h22:   res = a - b;
          6'h24:   res = a & b;
          6'h25:   res = a | b;
          6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: res = '0;
        endcase
      end
      6'h08: begin
        wreg = 1'b1;
        res  = ea;
      end
      6'h23: begin
        wreg = 1'b1;
        lat  = 5;
        res  = m_mem[ea[9:2]];
      end
      6'h2B: begin
        wr = 1'b1;
        wa = ea;
        wd = b;
        m_mem[ea[9:2]] = b;
      end
      6'h04: begin
        lat = 3;
        if (a == b) nxt = nxt + (sx << 2);
      end
      6'h03: begin
        lat  = 3;
        wreg = 1'b1;
        dst  = 5'd31;
        res  = nxt;
        nxt  = {nxt[31:28], ins[25:0], 2'b00};
      end
      default: ;
    endcase
    if (wreg && dst != 5'd0) m_rf[dst] = res;
    m_pc = nxt;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_pc", pc, 32'h0);
    check("rst_ret", retired, 0);
    check("rst_err", err, 0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  // Entered and left just after a rising edge; logs completed writes.
  task automatic wait_retire(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 300) begin
      @(negedge CLK);
      lat++;
      if (mem_req && mem_we && mem_ready) begin
        mem[mem_addr[9:2]] = mem_wdata;
        wr_cnt++;
        last_wa = mem_addr;
        last_wd = mem_wdata;
      end
      ok = retired;
      @(posedge CLK);
      #1;
      if (rnd_rdy) mem_ready = 1'($urandom_range(0, 1));
    end
  endtask

  int          lat;
  int          elat;
  int          steps;
  int          cnt0;
  bit          ok;
  bit          ewr;
  logic [31:0] ewa;
  logic [31:0] ewd;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST_N     = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    tv[0]  = '{32'h000, enc_i(6'h08, 5'd1, 5'd0, 16'd5),
               4, 32'h004, 0, 32'h0, 32'h0};
    tv[1]  = '{32'h004, enc_i(6'h08, 5'd2, 5'd0, 16'd7),
               4, 32'h008, 0, 32'h0, 32'h0};
    tv[2]  = '{32'h008, enc_r(6'h20, 5'd3, 5'd1, 5'd2),
               4, 32'h00C, 0, 32'h0, 32'h0};
    tv[3]  = '{32'h00C, enc_i(6'h2B, 5'd3, 5'd0, 16'd8),
               4, 32'h010, 1, 32'h8, 32'd12};
    tv[4]  = '{32'h010, enc_i(6'h23, 5'd4, 5'd0, 16'd8),
               5, 32'h014, 0, 32'h0, 32'h0};
    tv[5]  = '{32'h014, enc_i(6'h2B, 5'd4, 5'd0, 16'h200),
               4, 32'h018, 1, 32'h200, 32'd12};
    tv[6]  = '{32'h018, enc_i(6'h04, 5'd2, 5'd1, 16'd5),
               3, 32'h01C, 0, 32'h0, 32'h0};
    tv[7]  = '{32'h01C, enc_r(6'h20, 5'd0, 5'd1, 5'd2),
               4, 32'h020, 0, 32'h0, 32'h0};
    tv[8]  = '{32'h020, enc_j(6'h03, 26'h40),
               3, 32'h100, 0, 32'h0, 32'h0};
    tv[9]  = '{32'h100, enc_i(6'h2B, 5'd31, 5'd0, 16'h204),
               4, 32'h104, 1, 32'h204, 32'h24};
    tv[10] = '{32'h104, enc_i(6'h2B, 5'd0, 5'd0, 16'h208),
               4, 32'h108, 1, 32'h208, 32'h0};
    tv[11] = '{32'h108, enc_r(6'h22, 5'd6, 5'd1, 5'd2),
               4, 32'h10C, 0, 32'h0, 32'h0};
    tv[12] = '{32'h10C, enc_r(6'h2A, 5'd7, 5'd6, 5'd1),
               4, 32'h110, 0, 32'h0, 32'h0};
    tv[13] = '{32'h110, enc_r(6'h24, 5'd8, 5'd6, 5'd2),
               4, 32'h114, 0, 32'h0, 32'h0};
    tv[14] = '{32'h114, enc_r(6'h25, 5'd9, 5'd7, 5'd8),
               4, 32'h118, 0, 32'h0, 32'h0};
    tv[15] = '{32'h118, enc_i(6'h2B, 5'd9, 5'd0, 16'h20C),
               4, 32'h11C, 1, 32'h20C, 32'd7};
    tv[16] = '{32'h11C, enc_i(6'h2B, 5'd7, 5'd0, 16'h210),
               4, 32'h120, 1, 32'h210, 32'd1};
    tv[17] = '{32'h120, enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF),
               3, 32'h120, 0, 32'h0, 32'h0};
    tv[18] = '{32'h120, enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF),
               3, 32'h120, 0, 32'h0, 32'h0};

    for (int i = 0; i < 19; i++) mem[tv[i].addr[9:2]] = tv[i].ins;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      cnt0 = wr_cnt;
      wait_retire(lat, ok);
      check($sformatf("tv%0d_lat", i), lat, tv[i].lat);
      check($sformatf("tv%0d_pc", i), pc, tv[i].npc);
      check($sformatf("tv%0d_wrcnt", i), wr_cnt - cnt0, 32'(tv[i].wr));
      if (tv[i].wr) begin
        check($sformatf("tv%0d_wa", i), last_wa, tv[i].wa);
        check($sformatf("tv%0d_wd", i), last_wd, tv[i].wd);
      end
    end

    // Fetch held off by mem_ready=0 for three edges.
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = enc_i(6'h08, 5'd1, 5'd0, 16'd9);
    mem[1] = enc_i(6'h2B, 5'd1, 5'd0, 16'h200);
    mem_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("stall_req", mem_req, 1);
      check("stall_addr", mem_addr, 32'h0);
      check("stall_pc", pc, 32'h0);
      check("stall_ret", retired, 0);
    end
    mem_ready = 1'b1;
    @(posedge CLK);
    #1;
    check("stall_pc4", pc, 32'h4);
    wait_retire(lat, ok);
    check("stall_addi_lat", lat, 3);
    cnt0 = wr_cnt;
    wait_retire(lat, ok);
    check("stall_sw_lat", lat, 4);
    check("stall_sw_wrcnt", wr_cnt - cnt0, 1);
    check("stall_sw_wd", last_wd, 32'd9);

    // Misaligned lw traps without touching memory.
    mem[0] = enc_i(6'h23, 5'd5, 5'd0, 16'd6);
    do_reset();
    repeat (2) @(negedge CLK);
    for (int c = 3; c <= 8; c++) begin
      @(negedge CLK);
      check("trap_req", mem_req, 0);
      check("trap_ret", retired, 0);
      if (c >= 4) check("trap_err", err, 1);
    end
    check("trap_pc", pc, 32'h4);

    // Reset while a store is stalled.
    mem[0] = enc_i(6'h2B, 5'd0, 5'd0, 16'h200);
    do_reset();
    @(negedge CLK);
    @(negedge CLK);
    mem_ready = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("abort_req_pre", mem_req, 1);
    check("abort_we_pre", mem_we, 1);
    check("abort_addr_pre", mem_addr, 32'h200);
    #2 RST_N = 1'b0;
    #1;
    check("abort_req", mem_req, 0);
    check("abort_we", mem_we, 0);
    check("abort_pc", pc, 32'h0);
    mem_ready = 1'b1;
    @(negedge CLK);
    check("abort_req_hold", mem_req, 0);

    // Random program, random mem_ready, register dump by stores.
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 40; i++) mem[i] = rand_ins();
    for (int i = 1; i < 32; i++)
      mem[39 + i] = enc_i(6'h2B, 5'(i), 5'd0, 16'(32'h300 + 4 * i));
    mem[71] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    m_mem = mem;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pc = '0;
    do_reset();
    rnd_rdy   = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    steps = 0;
    while (m_pc != 32'h11C && steps < 150) begin
      steps++;
      cnt0 = wr_cnt;
      model_step(ewr, ewa, ewd, elat);
      wait_retire(lat, ok);
      check("rnd_retire", ok, 1);
      if (!ok) break;
      check("rnd_lat_min", lat >= elat, 1);
      check("rnd_pc", pc, m_pc);
      check("rnd_wrcnt", wr_cnt - cnt0, 32'(ewr));
      if (ewr) begin
        check("rnd_wa", last_wa, ewa);
        check("rnd_wd", last_wd, ewd);
      end
    end
    check("rnd_err", err, 0);
    rnd_rdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
